// File: rtl/lsu_align_pkg.sv
`default_nettype none
// ============================================================================
// Module : lsu_align_pkg
// Brief  : Shared access-size encodings, FSM state codes and legality check
//          for the load/store alignment unit.
// Rev    : 1.0  initial release
// ============================================================================
package lsu_align_pkg;

    // RV32 funct3 access sizes
    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    localparam int         ST_W    = 2;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_FAIL = 2'd3;

    function automatic logic lsu_illegal(input logic       wr,
                                         input logic [2:0] size,
                                         input logic [1:0] off);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_BU:   bad = wr;
            SZ_H:    bad = off[0];
            SZ_HU:   bad = wr | off[0];
            SZ_W:    bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align_if.sv
`default_nettype none
// ============================================================================
// Module : lsu_align_if
// Brief  : Request/response and data-memory handshake bundle for lsu_align.
// Rev    : 1.0  initial release
// ============================================================================
interface lsu_align_if;
    logic        req;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        err;
    logic        busy;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Requester and memory side together
    modport master (
        output req, wr, size, addr, wdata, mem_ready, mem_rdata,
        input  rdata, done, err, busy, mem_valid, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport slave (
        input  req, wr, size, addr, wdata, mem_ready, mem_rdata,
        output rdata, done, err, busy, mem_valid, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_lane_fmt.sv
`default_nettype none
// ============================================================================
// Module : lsu_lane_fmt
// Brief  : Combinational store lane replication / byte enables and load
//          extract with sign or zero extension.
// Rev    : 1.0  initial release
// ============================================================================
module lsu_lane_fmt
    import lsu_align_pkg::*;
(
    input  wire logic        i_wr,
    input  wire logic [2:0]  i_size,
    input  wire logic [1:0]  i_off,
    input  wire logic [31:0] i_wdata,
    input  wire logic [31:0] i_rdata,
    output logic             o_illegal,
    output logic [3:0]       o_be,
    output logic [31:0]      o_wdata,
    output logic [31:0]      o_rdata
);
    logic [31:0] w_shift;

    assign o_illegal = lsu_illegal(i_wr, i_size, i_off);
    assign w_shift   = i_rdata >> {i_off, 3'b000};

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        if (i_wr) begin
            case (i_size)
                SZ_B: begin
                    o_be    = 4'b0001 << i_off;
                    o_wdata = {4{i_wdata[7:0]}};
                end
                SZ_H: begin
                    o_be    = i_off[1] ? 4'b1100 : 4'b0011;
                    o_wdata = {2{i_wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (i_size)
            SZ_B:    o_rdata = {{24{w_shift[7]}}, w_shift[7:0]};
            SZ_BU:   o_rdata = {24'd0, w_shift[7:0]};
            SZ_H:    o_rdata = {{16{w_shift[15]}}, w_shift[15:0]};
            SZ_HU:   o_rdata = {16'd0, w_shift[15:0]};
            default: o_rdata = w_shift;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module : lsu_align
// Brief  : Load/store unit: alignment check, word-aligned memory handshake
//          with timeout, and load result formatting.
// Rev    : 1.0  initial release
// ============================================================================
module lsu_align
    import lsu_align_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  wire logic  clk,
    input  wire logic  rst,
    lsu_align_if.slave bus
);
    logic [ST_W-1:0]  r_state;
    logic [ST_W-1:0]  w_state_nxt;
    logic             r_wr;
    logic [2:0]       r_size;
    logic [1:0]       r_off;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [31:0]      r_rdata;
    logic             r_done;
    logic             r_err;
    logic             r_mem_valid;
    logic             r_mem_we;
    logic [31:0]      r_mem_addr;
    logic [3:0]       r_mem_be;
    logic [31:0]      r_mem_wdata;

    logic             w_idle;
    logic             w_timeout;
    logic             w_illegal;
    logic             w_fmt_wr;
    logic [2:0]       w_fmt_size;
    logic [1:0]       w_fmt_off;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [31:0]      w_rdata;
    logic             w_cap_req;
    logic             w_cap_rdata;
    logic             w_valid_nxt;
    logic             w_we_nxt;
    logic             w_done_nxt;
    logic             w_err_nxt;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_timeout = (w_cnt_inc == CNT_W'(TIMEOUT));

    // The formatter serves live request fields in IDLE and captured ones after
    assign w_fmt_wr   = w_idle ? bus.wr        : r_wr;
    assign w_fmt_size = w_idle ? bus.size      : r_size;
    assign w_fmt_off  = w_idle ? bus.addr[1:0] : r_off;

    lsu_lane_fmt u_fmt (
        .i_wr      (w_fmt_wr),
        .i_size    (w_fmt_size),
        .i_off     (w_fmt_off),
        .i_wdata   (bus.wdata),
        .i_rdata   (bus.mem_rdata),
        .o_illegal (w_illegal),
        .o_be      (w_be),
        .o_wdata   (w_wdata),
        .o_rdata   (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.req) w_state_nxt = w_illegal ? ST_FAIL : ST_WAIT;
            ST_WAIT: begin
                // A ready on the timeout cycle still completes normally
                if (bus.mem_ready)  w_state_nxt = ST_RESP;
                else if (w_timeout) w_state_nxt = ST_FAIL;
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            ST_FAIL: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cap_req   = w_idle & bus.req;
        w_cap_rdata = (r_state == ST_WAIT) & bus.mem_ready & ~r_wr;
        w_valid_nxt = (w_state_nxt == ST_WAIT);
        w_we_nxt    = w_valid_nxt & w_fmt_wr;
        w_done_nxt  = (r_state == ST_RESP) | (r_state == ST_FAIL);
        w_err_nxt   = (r_state == ST_FAIL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr        <= 1'b0;
            r_size      <= 3'd0;
            r_off       <= 2'd0;
            r_cnt       <= '0;
            r_rdata     <= 32'd0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_be    <= 4'd0;
            r_mem_wdata <= 32'd0;
        end else begin
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_mem_valid <= w_valid_nxt;
            r_mem_we    <= w_we_nxt;
            if (w_cap_req) begin
                r_wr   <= bus.wr;
                r_size <= bus.size;
                r_off  <= bus.addr[1:0];
                if (!w_illegal) begin
                    r_mem_addr  <= {bus.addr[31:2], 2'b00};
                    r_mem_be    <= w_be;
                    r_mem_wdata <= w_wdata;
                end
            end
            if (w_idle)
                r_cnt <= '0;
            else if ((r_state == ST_WAIT) && !bus.mem_ready)
                r_cnt <= w_cnt_inc;
            if (w_cap_rdata)
                r_rdata <= w_rdata;
        end
    end

    assign bus.rdata     = r_rdata;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.busy      = ~w_idle;
    assign bus.mem_valid = r_mem_valid;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_wdata = r_mem_wdata;
endmodule
`default_nettype wire
